// File: rtl/stream_writer_if.sv
// Wishbone bus bundle shared by the stream master, stream_writer and the interconnect.
interface wshb_if #(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [ADDR_WIDTH-1:0]     adr;
    logic [8*DATA_BYTES-1:0]   dat_ms;
    logic [8*DATA_BYTES-1:0]   dat_sm;
    logic [DATA_BYTES-1:0]     sel;
    logic [2:0]                cti;
    logic [1:0]                bte;
    logic                      ack;
    logic                      err;
    logic                      rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/stream_writer.sv
// Terminates the pixel stream as a Wishbone slave, buffers writes in a show-ahead FIFO
// and replays them as Wishbone master writes, pulsing frame_done once per frame.
module stream_writer #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    wshb_if.slave                         wshb_ifs,
    wshb_if.master                        wshb_ifm,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned TOTAL = HDISP * VDISP;
    localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
    } entry_t;

    logic             wr_req_c;
    logic             rd_req_c;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;
    entry_t           in_c;
    entry_t           head_c;
    entry_t           next_c;
    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             act_q;
    logic             act_d;
    entry_t           out_q;
    entry_t           out_d;
    logic [CNT_W-1:0] pix_cnt;
    logic             unused_c;

    // Slave side: accept writes unless full, answer reads immediately with zero data
    assign wr_req_c = wshb_ifs.cyc & wshb_ifs.stb & wshb_ifs.we;
    assign rd_req_c = wshb_ifs.cyc & wshb_ifs.stb & ~wshb_ifs.we;
    assign full_c   = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty_c  = (fifo_level == '0);
    assign push_c   = wr_req_c & ~full_c;
    assign pop_c    = (state_q == S_WRITE) & wshb_ifm.ack;

    assign wshb_ifs.ack    = push_c | rd_req_c;
    assign wshb_ifs.dat_sm = '0;
    assign wshb_ifs.err    = 1'b0;
    assign wshb_ifs.rty    = 1'b0;

    assign in_c.adr = wshb_ifs.adr;
    assign in_c.dat = wshb_ifs.dat_ms;
    assign in_c.sel = wshb_ifs.sel;

    assign head_c = mem[rd_ptr];
    assign next_c = mem[rd_ptr + PTR_W'(1)];

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge sys_clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_c;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            act_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            out_q   <= out_d;
        end
    end

    // On ack with more queued, preload the entry behind the head so stb stays high
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (!empty_c) begin
                    state_d = S_WRITE;
                    act_d   = 1'b1;
                    out_d   = head_c;
                end
            end
            S_WRITE: begin
                if (wshb_ifm.ack) begin
                    if (fifo_level > LVL_W'(1)) begin
                        out_d = next_c;
                    end else begin
                        state_d = S_IDLE;
                        act_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                act_d   = 1'b0;
            end
        endcase
    end

    assign wshb_ifm.cyc    = act_q;
    assign wshb_ifm.stb    = act_q;
    assign wshb_ifm.we     = act_q;
    assign wshb_ifm.adr    = out_q.adr;
    assign wshb_ifm.dat_ms = out_q.dat;
    assign wshb_ifm.sel    = out_q.sel;
    assign wshb_ifm.cti    = 3'b000;
    assign wshb_ifm.bte    = 2'b00;

    // Completed-write counter, wraps once per frame
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (pop_c) begin
                if (pix_cnt == CNT_W'(TOTAL - 1)) begin
                    pix_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_cnt <= pix_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign unused_c = ^{wshb_ifs.cti, wshb_ifs.bte, wshb_ifm.dat_sm, wshb_ifm.err, wshb_ifm.rty};

endmodule
